// File: rtl/iter_shifter_pkg.sv
// shifter_pkg: shared types for the iterative shifter and its step element.
//   shift_op_t : operation encoding carried on sel_i (SLL/SRL/SRA/ROL).
//   sh_state_t : FSM states of iter_shifter.
// Optional feature macro (consumed by iter_shifter and shift_step):
//   SHIFTER_ROTATE_EN - compiles in the ROL step and the mod-WIDTH count.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sh_state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/response handshake bundle for iter_shifter.
//   Request : valid_i, ready_o, sel_i, A_i, shamt_i
//   Response: valid_o, ready_i, data_o
// Modports:
//   slave  - the shifter side (accepts requests, produces results)
//   master - the requester/consumer side
interface iter_shifter_if #(
    parameter int WIDTH = 8
);
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       sel_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] shamt_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;

    modport slave (
        input  valid_i, sel_i, A_i, shamt_i, ready_i,
        output ready_o, valid_o, data_o
    );

    modport master (
        output valid_i, sel_i, A_i, shamt_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// shift_step: combinational single-position shift (op, in) -> out.
// Used once on the iterative shifter's working register; it is also the
// chain element of the combinational barrel shifter.
//   op_i  - operation (shift_op_t)
//   in_i  - operand
//   out_o - operand shifted/rotated by one position
// Optional macro: SHIFTER_ROTATE_EN enables the ROL step; without it
// SH_ROL falls into the SLL step.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  shift_op_t        op_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = {in_i[WIDTH-2:0], 1'b0};
        case (op_i)
            SH_SRL: out_o = {1'b0, in_i[WIDTH-1:1]};
            SH_SRA: out_o = {in_i[WIDTH-1], in_i[WIDTH-1:1]};
`ifdef SHIFTER_ROTATE_EN
            SH_ROL: out_o = {in_i[WIDTH-2:0], in_i[WIDTH-1]};
`endif
            default: out_o = {in_i[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter, one single-position step per clock.
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous active-low reset
//   bus     - iter_shifter_if.slave: request (valid_i/ready_o/sel_i/A_i/
//             shamt_i) and result (valid_o/ready_i/data_o) handshakes
// Outputs are decoded from state or taken straight from flops, so there is
// no combinational input-to-output path.
// Optional macro: SHIFTER_ROTATE_EN - sel_i=11 performs ROL with count
// shamt mod WIDTH; otherwise sel_i=11 behaves exactly as SLL.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    iter_shifter_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    sh_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    shift_op_t        op_q, op_d;

    shift_op_t        req_op;
    logic [CW-1:0]    eff_cnt;
    logic [WIDTH-1:0] step_out;

    // Request decode; without rotate support ROL requests become SLL so the
    // whole downstream path (count + step) treats them identically.
    always_comb begin
        req_op = shift_op_t'(bus.sel_i);
`ifndef SHIFTER_ROTATE_EN
        if (req_op == SH_ROL) req_op = SH_SLL;
`endif
    end

    // Shifting WIDTH times already produces 0 / all-sign, so saturation is
    // just clamping the count at WIDTH.
    always_comb begin
        eff_cnt = (bus.shamt_i >= W_VAL) ? CW'(WIDTH) : CW'(bus.shamt_i);
`ifdef SHIFTER_ROTATE_EN
        if (req_op == SH_ROL) eff_cnt = CW'(bus.shamt_i % W_VAL);
`endif
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .in_i  (work_q),
        .out_o (step_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_i) begin
                    work_d  = bus.A_i;
                    op_d    = req_op;
                    cnt_d   = eff_cnt;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = step_out;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            op_q    <= SH_SLL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            op_q    <= op_d;
        end
    end

    assign bus.ready_o = (state_q == ST_IDLE);
    assign bus.valid_o = (state_q == ST_DONE);
    assign bus.data_o  = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed, self-checking bench for iter_shifter (WIDTH=8).
// Inputs change #1 after a rising edge; outputs are sampled at the same
// point, well away from the next edge.
module tb_iter_shifter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   lat;

    iter_shifter_if #(.WIDTH(8)) bus ();

    iter_shifter #(.WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request for a single accepting edge.
    task automatic issue(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] sh);
        bus.valid_i = 1'b1;
        bus.sel_i   = sel;
        bus.A_i     = a;
        bus.shamt_i = sh;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    // Edges from the accepting edge until valid_o is seen, bounded.
    task automatic wait_result(output int l);
        l = 0;
        while (!bus.valid_o && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic handshake();
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] sel, input logic [7:0] a,
                          input logic [7:0] sh, input logic [7:0] exp_d, input int exp_lat);
        int l;
        chk({tag, "_rdy_in"}, 32'(bus.ready_o), 32'd1);
        issue(sel, a, sh);
        wait_result(l);
        chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
        chk({tag, "_data"}, 32'(bus.data_o), 32'(exp_d));
        handshake();
        chk({tag, "_idle"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.sel_i   = 2'b00;
        bus.A_i     = 8'h00;
        bus.shamt_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_data",  32'(bus.data_o),  32'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ops and saturation
        run_op("sll81_3",   2'b00, 8'h81, 8'd3,   8'h08, 4);
        run_op("sra90_2",   2'b10, 8'h90, 8'd2,   8'hE4, 3);
        run_op("sra90_200", 2'b10, 8'h90, 8'd200, 8'hFF, 9);
        run_op("srl90_9",   2'b01, 8'h90, 8'd9,   8'h00, 9);
        run_op("sll01_8",   2'b00, 8'h01, 8'd8,   8'h00, 9);
`ifdef SHIFTER_ROTATE_EN
        run_op("rol81_9",   2'b11, 8'h81, 8'd9,   8'h03, 2);
`else
        run_op("rol81_9",   2'b11, 8'h81, 8'd9,   8'h00, 9);
`endif

        // Zero shift plus consumer stall with an ignored request in the middle
        issue(2'b01, 8'h5A, 8'd0);
        wait_result(lat);
        chk("z_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.valid_i = 1'b1;
                bus.sel_i   = 2'b00;
                bus.A_i     = 8'hFF;
                bus.shamt_i = 8'd1;
            end else begin
                bus.valid_i = 1'b0;
            end
            chk("stall_valid", 32'(bus.valid_o), 32'd1);
            chk("stall_data",  32'(bus.data_o),  32'h5A);
            chk("stall_ready", 32'(bus.ready_o), 32'd0);
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
        chk("stall_end_data", 32'(bus.data_o), 32'h5A);
        handshake();
        chk("post_stall_ready", 32'(bus.ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_stall_nores", 32'(bus.valid_o), 32'd0);
        end

        // Reset in the middle of a shift
        issue(2'b00, 8'hFF, 8'd7);
        @(posedge clk); #1;
        chk("mid_busy", 32'(bus.ready_o), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.ready_o), 32'd1);
        chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        chk("mid_rst_data",  32'(bus.data_o),  32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("srlF0_4", 2'b01, 8'hF0, 8'd4, 8'h0F, 5);

        // Back-to-back with valid_i held and ready_i held
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.sel_i   = 2'b00;
        bus.A_i     = 8'h01;
        bus.shamt_i = 8'd1;
        @(posedge clk); #1;
        bus.sel_i   = 2'b01;
        bus.A_i     = 8'h80;
        bus.shamt_i = 8'd2;
        wait_result(lat);
        chk("b2b1_lat",  32'(lat), 32'd2);
        chk("b2b1_data", 32'(bus.data_o), 32'h02);
        @(posedge clk); #1;
        chk("b2b_gap_ready", 32'(bus.ready_o), 32'd1);
        chk("b2b_gap_valid", 32'(bus.valid_o), 32'd0);
        @(posedge clk); #1;
        chk("b2b2_accepted", 32'(bus.ready_o), 32'd0);
        bus.valid_i = 1'b0;
        wait_result(lat);
        chk("b2b2_lat",  32'(lat), 32'd3);
        chk("b2b2_data", 32'(bus.data_o), 32'h20);
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        chk("b2b_end_ready", 32'(bus.ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
